// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared FSM state type and WIDTH limits for the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_WIDTH_MIN = 2;
  localparam int c_WIDTH_MAX = 64;

endpackage

`default_nettype wire

// File: rtl/half_adder_cell.sv
// ============================================================================
// Module   : half_adder_cell
// Purpose  : One-bit half adder, the building block of the serial datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : WIDTH-bit serial adder, LSB first, one bit per clock. Define
//            SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b + 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_psum;
  logic [WIDTH-1:0]   r_sum;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic               r_cout;

  logic               w_sub;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_load;
  logic               w_last;
  logic               w_s0;
  logic               w_c0;
  logic               w_bit_s;
  logic               w_c1;
  logic               w_carry_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
  assign w_b_in = b ^ {WIDTH{w_sub}};
  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_state == RUN) && (r_cnt == c_CNT_LAST);

  half_adder_cell u_ha_ab (
    .a (r_a_sh[0]),
    .b (r_b_sh[0]),
    .s (w_s0),
    .c (w_c0)
  );

  half_adder_cell u_ha_cin (
    .a (w_s0),
    .b (r_carry),
    .s (w_bit_s),
    .c (w_c1)
  );

  assign w_carry_nxt = w_c0 | w_c1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == c_CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sh  <= a;
      r_b_sh  <= w_b_in;
      r_carry <= w_sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_carry_nxt;
      r_psum  <= {w_bit_s, r_psum[WIDTH-1:1]};
      // Hold the counter on the last bit so it never wraps.
      if (!w_last) r_cnt <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        r_sum  <= {w_bit_s, r_psum[WIDTH-1:1]};
        r_cout <= w_carry_nxt;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire
